pc_fetch: RTL and testbench

Fetch stage of the pipelined RV32I core. Holds the program counter and drives the instruction-memory request handshake. Selects the next PC from the sequential `PCPlus4F_i` or the execute-stage branch/jump `PCTargetE_i`, both produced by the `addr` block. Owns the IF/ID pipeline register, with stall, flush and redirect-while-outstanding handling.

---
 rtl/pc_fetch.sv | 157 +++++++++++++++
 tb/tb_pc_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: RV32I fetch stage. It holds the PC, drives the instruction-memory handshake and owns the IF/ID register.
// Optional macro FETCH_MISALIGN_EN adds MisalignD_o and passes PCTargetE_i through unmasked.
module pc_fetch #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  PCSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4F_i,
  input  logic                  StallF_i,
  input  logic                  StallD_i,
  input  logic                  FlushD_i,
  output logic [DATA_WIDTH-1:0] PCF_o,
  output logic                  IMemReq_o,
  output logic [DATA_WIDTH-1:0] IMemAddr_o,
  input  logic                  IMemReady_i,
  input  logic [DATA_WIDTH-1:0] IMemRData_i,
  output logic [DATA_WIDTH-1:0] InstrD_o,
  output logic [DATA_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] PCPlus4D_o,
  output logic                  ValidD_o,
  output logic                  FetchBusy_o
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                  MisalignD_o
`endif
);

  // state | meaning
  // FETCH | request at PC; accept, redirect or capture into the hold buffer
  // DROP  | wrong-path request outstanding; its response is discarded
  // HOLD  | word parked in the hold buffer while StallF is asserted
  typedef enum logic [1:0] {S_FETCH, S_DROP, S_HOLD} state_t;

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_redir;
  logic [DATA_WIDTH-1:0] r_instrd;
  logic [DATA_WIDTH-1:0] r_pcd;
  logic [DATA_WIDTH-1:0] r_pc4d;
  logic                  r_validd;

  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_req;
  logic                  w_hs;
  logic                  w_deliver;
  logic [DATA_WIDTH-1:0] w_dlv_instr;

`ifdef FETCH_MISALIGN_EN
  logic r_misd;
  assign w_target    = PCTargetE_i;
  assign MisalignD_o = r_misd;
`else
  assign w_target = PCTargetE_i & ~DATA_WIDTH'(3);
`endif

  // The request is held low during reset even though the state is already FETCH.
  assign w_req       = (r_state != S_HOLD) && !rst_i;
  assign w_hs        = w_req && IMemReady_i;
  assign w_deliver   = !PCSrcE_i && !StallF_i &&
                       (((r_state == S_FETCH) && w_hs) || (r_state == S_HOLD));
  assign w_dlv_instr = (r_state == S_HOLD) ? r_hold : IMemRData_i;

  assign PCF_o       = r_pc;
  assign IMemReq_o   = w_req;
  assign IMemAddr_o  = r_pc;
  assign FetchBusy_o = w_req && !IMemReady_i;
  assign InstrD_o    = r_instrd;
  assign PCD_o       = r_pcd;
  assign PCPlus4D_o  = r_pc4d;
  assign ValidD_o    = r_validd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_VECTOR;
      r_hold  <= '0;
      r_redir <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_hs) begin
            if (PCSrcE_i) begin
              r_pc <= w_target;
            end else if (!StallF_i) begin
              r_pc <= PCPlus4F_i;
            end else begin
              r_hold  <= IMemRData_i;
              r_state <= S_HOLD;
            end
          end else if (PCSrcE_i) begin
            r_redir <= w_target;
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (w_hs) begin
            r_pc    <= PCSrcE_i ? w_target : r_redir;
            r_state <= S_FETCH;
          end else if (PCSrcE_i) begin
            r_redir <= w_target;
          end
        end
        S_HOLD: begin
          if (PCSrcE_i) begin
            r_pc    <= w_target;
            r_state <= S_FETCH;
          end else if (!StallF_i) begin
            r_pc    <= PCPlus4F_i;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instrd <= NOP;
      r_pcd    <= '0;
      r_pc4d   <= '0;
      r_validd <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      r_misd   <= 1'b0;
`endif
    end else if (FlushD_i) begin
      r_instrd <= NOP;
      r_validd <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      r_misd   <= 1'b0;
`endif
    end else if (StallD_i) begin
      r_instrd <= r_instrd;
    end else if (w_deliver) begin
      r_instrd <= w_dlv_instr;
      r_pcd    <= r_pc;
      r_pc4d   <= PCPlus4F_i;
      r_validd <= 1'b1;
`ifdef FETCH_MISALIGN_EN
      r_misd   <= |r_pc[1:0];
`endif
    end else begin
      r_instrd <= NOP;
      r_validd <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      r_misd   <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: scoreboard of expected IF/ID words plus per-scenario inline checks.
// Build with FETCH_MISALIGN_EN defined to also exercise MisalignD_o.
module tb_pc_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        PCSrcE_i = 1'b0;
  logic [31:0] PCTargetE_i = '0;
  logic [31:0] PCPlus4F_i;
  logic        StallF_i = 1'b0;
  logic        StallD_i = 1'b0;
  logic        FlushD_i = 1'b0;
  logic [31:0] PCF_o;
  logic        IMemReq_o;
  logic [31:0] IMemAddr_o;
  logic        IMemReady_i = 1'b1;
  logic [31:0] IMemRData_i;
  logic [31:0] InstrD_o;
  logic [31:0] PCD_o;
  logic [31:0] PCPlus4D_o;
  logic        ValidD_o;
  logic        FetchBusy_o;
`ifdef FETCH_MISALIGN_EN
  logic        MisalignD_o;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Environment: the addr block's PC+4 and a memory returning a tagged word per address.
  assign PCPlus4F_i  = PCF_o + 32'd4;
  assign IMemRData_i = IMemReady_i ? memw(IMemAddr_o) : 32'hDEAD_BEEF;

  pc_fetch #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .PCSrcE_i(PCSrcE_i), .PCTargetE_i(PCTargetE_i), .PCPlus4F_i(PCPlus4F_i),
    .StallF_i(StallF_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i),
    .PCF_o(PCF_o), .IMemReq_o(IMemReq_o), .IMemAddr_o(IMemAddr_o),
    .IMemReady_i(IMemReady_i), .IMemRData_i(IMemRData_i),
    .InstrD_o(InstrD_o), .PCD_o(PCD_o), .PCPlus4D_o(PCPlus4D_o),
    .ValidD_o(ValidD_o), .FetchBusy_o(FetchBusy_o)
`ifdef FETCH_MISALIGN_EN
    , .MisalignD_o(MisalignD_o)
`endif
  );

  task automatic expect_word(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = memw(pc);
    sb.push_back(e);
  endtask

  // One clock; afterwards any newly loaded IF/ID word is popped and compared.
  task automatic cyc();
    logic held;
    exp_t e;
    held = StallD_i | FlushD_i;
    @(posedge clk_i);
    #1;
    if (!held && ValidD_o) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: PCD_o=%h InstrD_o=%h delivered, nothing expected", PCD_o, InstrD_o);
      end else begin
        e = sb.pop_front();
        if (PCD_o !== e.pc || InstrD_o !== e.instr || PCPlus4D_o !== e.pc + 32'd4) begin
          failures++;
          $display("FAIL sb_word: got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                   PCD_o, InstrD_o, PCPlus4D_o, e.pc, e.instr, e.pc + 32'd4);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; PCSrcE_i = 1'b0; StallF_i = 1'b0; StallD_i = 1'b0; FlushD_i = 1'b0;
    IMemReady_i = 1'b1; PCTargetE_i = '0;
    sb.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (PCF_o !== 32'h0 || IMemReq_o !== 1'b0 || FetchBusy_o !== 1'b0) begin failures++;
      $display("FAIL reset_fetch: pcf=%h req=%b busy=%b want 0/0/0", PCF_o, IMemReq_o, FetchBusy_o); end
    checks++; if (InstrD_o !== 32'h13 || PCD_o !== 32'h0 || PCPlus4D_o !== 32'h0 || ValidD_o !== 1'b0) begin failures++;
      $display("FAIL reset_ifid: instr=%h pcd=%h pc4=%h valid=%b want 13/0/0/0", InstrD_o, PCD_o, PCPlus4D_o, ValidD_o); end
`ifdef FETCH_MISALIGN_EN
    checks++; if (MisalignD_o !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b want 0", MisalignD_o); end
`endif
    rst_i = 1'b0;
    #1;
    checks++; if (IMemReq_o !== 1'b1 || IMemAddr_o !== 32'h0) begin failures++;
      $display("FAIL reset_release_req: req=%b addr=%h want 1/0", IMemReq_o, IMemAddr_o); end
    @(posedge clk_i); #1;
    sb.delete();
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_word(32'(4 * i));
      checks++; if (PCF_o !== 32'(4 * i) || IMemAddr_o !== 32'(4 * i) || IMemReq_o !== 1'b1) begin failures++;
        $display("FAIL seq_pc: pcf=%h addr=%h req=%b want %h", PCF_o, IMemAddr_o, IMemReq_o, 32'(4 * i)); end
      cyc();
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL seq_drain: %0d pending want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_wait_states();
    do_reset();
    for (int i = 0; i < 2; i++) begin expect_word(32'(4 * i)); cyc(); end
    IMemReady_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (IMemAddr_o !== 32'h8 || FetchBusy_o !== 1'b1 || PCF_o !== 32'h8) begin failures++;
        $display("FAIL wait_addr: addr=%h busy=%b pcf=%h want 8/1/8", IMemAddr_o, FetchBusy_o, PCF_o); end
      cyc();
      checks++; if (ValidD_o !== 1'b0 || InstrD_o !== 32'h13) begin failures++;
        $display("FAIL wait_bubble: valid=%b instr=%h want 0/13", ValidD_o, InstrD_o); end
    end
    IMemReady_i = 1'b1;
    expect_word(32'h8);
    #1;
    checks++; if (FetchBusy_o !== 1'b0) begin failures++; $display("FAIL wait_ready_busy: got %b want 0", FetchBusy_o); end
    cyc();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL wait_drain: %0d pending want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 2; i++) begin expect_word(32'(4 * i)); cyc(); end
    IMemReady_i = 1'b0; PCSrcE_i = 1'b1; PCTargetE_i = 32'h40;
    #1;
    checks++; if (FetchBusy_o !== 1'b1 || IMemAddr_o !== 32'h8) begin failures++;
      $display("FAIL redir_outstanding: busy=%b addr=%h want 1/8", FetchBusy_o, IMemAddr_o); end
    cyc();
    PCSrcE_i = 1'b0;
    #1;
    checks++; if (IMemReq_o !== 1'b1 || IMemAddr_o !== 32'h8) begin failures++;
      $display("FAIL redir_drop_addr: req=%b addr=%h want 1/8", IMemReq_o, IMemAddr_o); end
    cyc();
    IMemReady_i = 1'b1;
    cyc();
    checks++; if (ValidD_o !== 1'b0 || PCF_o !== 32'h40 || IMemAddr_o !== 32'h40) begin failures++;
      $display("FAIL redir_dropped: valid=%b pcf=%h addr=%h want 0/40/40", ValidD_o, PCF_o, IMemAddr_o); end
    expect_word(32'h40);
    cyc();
    // Newest redirect wins while dropping.
    IMemReady_i = 1'b0; PCSrcE_i = 1'b1; PCTargetE_i = 32'h80; cyc();
    PCTargetE_i = 32'h90; cyc();
    PCSrcE_i = 1'b0; IMemReady_i = 1'b1; cyc();
    checks++; if (PCF_o !== 32'h90 || ValidD_o !== 1'b0) begin failures++;
      $display("FAIL redir_newest: pcf=%h valid=%b want 90/0", PCF_o, ValidD_o); end
    // Redirect coinciding with the dropped response uses the new target.
    IMemReady_i = 1'b0; PCSrcE_i = 1'b1; PCTargetE_i = 32'hA0; cyc();
    IMemReady_i = 1'b1; PCTargetE_i = 32'hB0; cyc();
    checks++; if (PCF_o !== 32'hB0 || ValidD_o !== 1'b0) begin failures++;
      $display("FAIL redir_coincide: pcf=%h valid=%b want b0/0", PCF_o, ValidD_o); end
    // Redirect on a completing fetch discards that word.
    PCTargetE_i = 32'hC0; cyc();
    checks++; if (PCF_o !== 32'hC0 || ValidD_o !== 1'b0) begin failures++;
      $display("FAIL redir_fetch: pcf=%h valid=%b want c0/0", PCF_o, ValidD_o); end
    PCSrcE_i = 1'b0;
    expect_word(32'hC0);
    cyc();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL redir_drain: %0d pending want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin expect_word(32'(4 * i)); cyc(); end
    StallF_i = 1'b1; StallD_i = 1'b1;
    cyc();
    IMemReady_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (IMemReq_o !== 1'b0 || FetchBusy_o !== 1'b0 || PCF_o !== 32'hC) begin failures++;
        $display("FAIL stall_hold: req=%b busy=%b pcf=%h want 0/0/c", IMemReq_o, FetchBusy_o, PCF_o); end
      checks++; if (PCD_o !== 32'h8 || ValidD_o !== 1'b1 || InstrD_o !== memw(32'h8)) begin failures++;
        $display("FAIL stall_ifid: pcd=%h valid=%b instr=%h want 8/1/%h", PCD_o, ValidD_o, InstrD_o, memw(32'h8)); end
      if (i == 0) cyc();
    end
    StallF_i = 1'b0; StallD_i = 1'b0;
    expect_word(32'hC);
    cyc();
    checks++; if (PCF_o !== 32'h10 || IMemAddr_o !== 32'h10) begin failures++;
      $display("FAIL stall_release: pcf=%h addr=%h want 10/10", PCF_o, IMemAddr_o); end
    // Redirect while holding discards the buffer.
    IMemReady_i = 1'b1; StallF_i = 1'b1; StallD_i = 1'b1;
    cyc();
    StallF_i = 1'b0; StallD_i = 1'b0; PCSrcE_i = 1'b1; PCTargetE_i = 32'h200;
    cyc();
    checks++; if (PCF_o !== 32'h200 || ValidD_o !== 1'b0) begin failures++;
      $display("FAIL stall_redirect: pcf=%h valid=%b want 200/0", PCF_o, ValidD_o); end
    PCSrcE_i = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL stall_drain: %0d pending want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_flush();
    do_reset();
    expect_word(32'h0); cyc();
    FlushD_i = 1'b1; StallD_i = 1'b1;
    cyc();
    checks++; if (InstrD_o !== 32'h13 || ValidD_o !== 1'b0) begin failures++;
      $display("FAIL flush_wins: instr=%h valid=%b want 13/0", InstrD_o, ValidD_o); end
    FlushD_i = 1'b0; StallD_i = 1'b0;
    expect_word(32'h8);
    cyc();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL flush_drain: %0d pending want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_wrap();
    do_reset();
    PCSrcE_i = 1'b1; PCTargetE_i = 32'hFFFF_FFFC;
    cyc();
    PCSrcE_i = 1'b0;
    expect_word(32'hFFFF_FFFC);
    cyc();
    checks++; if (PCF_o !== 32'h0 || PCPlus4D_o !== 32'h0) begin failures++;
      $display("FAIL wrap: pcf=%h pc4d=%h want 0/0", PCF_o, PCPlus4D_o); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL wrap_drain: %0d pending want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_misalign();
    logic [31:0] want_pc;
`ifdef FETCH_MISALIGN_EN
    want_pc = 32'h42;
`else
    want_pc = 32'h40;
`endif
    do_reset();
    PCSrcE_i = 1'b1; PCTargetE_i = 32'h42;
    cyc();
    PCSrcE_i = 1'b0;
    checks++; if (PCF_o !== want_pc) begin failures++; $display("FAIL misalign_pc: got %h want %h", PCF_o, want_pc); end
    expect_word(want_pc);
    cyc();
`ifdef FETCH_MISALIGN_EN
    checks++; if (MisalignD_o !== 1'b1) begin failures++; $display("FAIL misalign_flag: got %b want 1", MisalignD_o); end
    FlushD_i = 1'b1; cyc(); FlushD_i = 1'b0;
    checks++; if (MisalignD_o !== 1'b0) begin failures++; $display("FAIL misalign_flush: got %b want 0", MisalignD_o); end
`endif
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL misalign_drain: %0d pending want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    PCSrcE_i = 1'b1; PCTargetE_i = 32'hFC;
    cyc();
    PCSrcE_i = 1'b0;
    expect_word(32'hFC);
    cyc();
    IMemReady_i = 1'b0;
    #1;
    checks++; if (IMemReq_o !== 1'b1 || IMemAddr_o !== 32'h100 || ValidD_o !== 1'b1) begin failures++;
      $display("FAIL rstmid_pre: req=%b addr=%h valid=%b want 1/100/1", IMemReq_o, IMemAddr_o, ValidD_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (PCF_o !== 32'h0 || ValidD_o !== 1'b0 || IMemReq_o !== 1'b0 || InstrD_o !== 32'h13 || FetchBusy_o !== 1'b0) begin failures++;
      $display("FAIL rstmid_async: pcf=%h valid=%b req=%b instr=%h busy=%b want 0/0/0/13/0",
               PCF_o, ValidD_o, IMemReq_o, InstrD_o, FetchBusy_o); end
    IMemReady_i = 1'b1;
    cyc();
    checks++; if (PCF_o !== 32'h0 || ValidD_o !== 1'b0) begin failures++;
      $display("FAIL rstmid_ignore: pcf=%h valid=%b want 0/0", PCF_o, ValidD_o); end
    rst_i = 1'b0;
    expect_word(32'h0);
    cyc();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rstmid_drain: %0d pending want 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_redirect();
    test_stall();
    test_flush();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
